// File: rtl/exe_div_seq_if.sv
// Operand/result handshake between execute and the
// multi-cycle divide/remainder sequencer.
interface exe_div_seq_if #(
  parameter int XLEN = 64
);
  logic            div_valid_i;
  logic            div_ready_o;
  logic [1:0]      div_op_i;
  logic            div_word_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic            flush_i;
  logic [XLEN-1:0] div_out_o;
  logic            div_out_valid_o;
  logic            div_out_ready_i;
  logic            busy_o;

  modport master (
    output div_valid_i,
    output div_op_i,
    output div_word_i,
    output dividend_i,
    output divisor_i,
    output flush_i,
    output div_out_ready_i,
    input  div_ready_o,
    input  div_out_o,
    input  div_out_valid_o,
    input  busy_o
  );

  modport slave (
    input  div_valid_i,
    input  div_op_i,
    input  div_word_i,
    input  dividend_i,
    input  divisor_i,
    input  flush_i,
    input  div_out_ready_i,
    output div_ready_o,
    output div_out_o,
    output div_out_valid_o,
    output busy_o
  );
endinterface

// File: rtl/exe_div_seq.sv
// RV64M DIV/DIVU/REM/REMU (+W) sequencer: restoring
// radix-2 divider, one quotient bit per cycle.
module exe_div_seq #(
  parameter int XLEN = 64
) (
  input  logic         clk,
  input  logic         rst,
  exe_div_seq_if.slave dif
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int HW = XLEN - 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] out_q;
  logic [CW-1:0]   cnt_q;
  logic            rsel_q, word_q;
  logic            qneg_q, rneg_q, spec_q;
  logic            valid_q, busy_q;

  logic            accept, last;
  logic            sgn, is_rem, word;
  logic [XLEN-1:0] a_x, b_x, a_abs, b_abs;
  logic [XLEN-1:0] min_neg, spec_raw, spec_val;
  logic            sa, sb, div0, ovf;
  logic [XLEN:0]   sh;
  logic            ge;
  logic [XLEN-1:0] rem_n, quo_n, q_fix, r_fix;
  logic [XLEN-1:0] sel, res;

  assign dif.div_ready_o =
    (state_q == IDLE) & ~dif.flush_i;
  assign accept = dif.div_valid_i & dif.div_ready_o;
  assign last   = (cnt_q == CW'(1));

  // Operand preparation on the accept cycle
  assign sgn    = ~dif.div_op_i[0];
  assign is_rem = dif.div_op_i[1];
  assign word   = dif.div_word_i;

  always_comb begin
    a_x = dif.dividend_i;
    b_x = dif.divisor_i;
    if (word) begin
      a_x = {{HW{sgn & dif.dividend_i[31]}},
             dif.dividend_i[31:0]};
      b_x = {{HW{sgn & dif.divisor_i[31]}},
             dif.divisor_i[31:0]};
    end
  end

  assign sa    = sgn & a_x[XLEN-1];
  assign sb    = sgn & b_x[XLEN-1];
  assign a_abs = sa ? -a_x : a_x;
  assign b_abs = sb ? -b_x : b_x;

  assign min_neg = word ?
    {{(HW+1){1'b1}}, 31'b0} :
    {1'b1, {(XLEN-1){1'b0}}};

  assign div0 = (b_x == '0);
  assign ovf  = sgn & (a_x == min_neg) & (b_x == '1);

  always_comb begin
    spec_raw = '0;
    if (div0)
      spec_raw = is_rem ? a_x : '1;
    else
      spec_raw = is_rem ? '0 : a_x;
  end

  assign spec_val = word ?
    {{HW{spec_raw[31]}}, spec_raw[31:0]} :
    spec_raw;

  // One restoring step
  assign sh    = {rem_q, quo_q[XLEN-1]};
  assign ge    = (sh >= {1'b0, dvs_q});
  assign rem_n = ge ? XLEN'(sh - {1'b0, dvs_q})
                    : sh[XLEN-1:0];
  assign quo_n = {quo_q[XLEN-2:0], ge};

  assign q_fix = qneg_q ? -quo_n : quo_n;
  assign r_fix = rneg_q ? -rem_n : rem_n;
  assign sel   = rsel_q ? r_fix : q_fix;
  assign res   = word_q ?
    {{HW{sel[31]}}, sel[31:0]} : sel;

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: if (spec_q | last) state_d = DONE;
      DONE: if (dif.div_out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      rsel_q <= 1'b0;
      word_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      spec_q <= 1'b0;
    end else if (accept) begin
      rsel_q <= is_rem;
      word_q <= word;
      qneg_q <= sa ^ sb;
      rneg_q <= sa;
      spec_q <= div0 | ovf;
      dvs_q  <= b_abs;
      rem_q  <= '0;
      cnt_q  <= word ? CW'(XLEN/2) : CW'(XLEN);
      if (div0 | ovf)
        quo_q <= spec_val;
      else if (word)
        quo_q <= a_abs << (XLEN/2);
      else
        quo_q <= a_abs;
    end else if (state_q == CALC &&
                 !dif.flush_i) begin
      if (spec_q) begin
        out_q <= quo_q;
      end else begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q - CW'(1);
        if (last) out_q <= res;
      end
    end
  end

  assign dif.div_out_o       = out_q;
  assign dif.div_out_valid_o = valid_q;
  assign dif.busy_o          = busy_q;

endmodule

// File: tb/tb_exe_div_seq.sv
// Randomized + directed bench for exe_div_seq against
// an arithmetic reference model.
module tb_exe_div_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  exe_div_seq_if #(.XLEN(64)) dif ();

  exe_div_seq #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(
    input  logic [1:0]  op,
    input  logic        w,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output int          lat);
    logic        sg;
    logic [31:0] a32, b32, q32, r32, x32;
    logic [63:0] q64, r64;
    sg  = ~op[0];
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      lat = 32;
      if (b32 == 0) begin
        q32 = '1; r32 = a32; lat = 1;
      end else if (sg && a32 == 32'h8000_0000 &&
                   b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 0; lat = 1;
      end else if (sg) begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32;
        r32 = a32 % b32;
      end
      x32 = op[1] ? r32 : q32;
      return {{32{x32[31]}}, x32};
    end
    lat = 64;
    if (b == 0) begin
      q64 = '1; r64 = a; lat = 1;
    end else if (sg && a == 64'h8000_0000_0000_0000 &&
                 b == '1) begin
      q64 = a; r64 = 0; lat = 1;
    end else if (sg) begin
      q64 = $signed(a) / $signed(b);
      r64 = $signed(a) % $signed(b);
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return op[1] ? r64 : q64;
  endfunction

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'($urandom), 32'($urandom)}
                & 64'hFFFF_FFFF;
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  task automatic start(input logic [1:0]  op,
                       input logic        w,
                       input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    dif.div_valid_i = 1'b1;
    dif.div_op_i    = op;
    dif.div_word_i  = w;
    dif.dividend_i  = a;
    dif.divisor_i   = b;
    @(posedge clk);
    #1;
    dif.div_valid_i = 1'b0;
    dif.div_op_i    = 2'($urandom);
    dif.div_word_i  = 1'($urandom);
    dif.dividend_i  = {32'($urandom), 32'($urandom)};
    dif.divisor_i   = {32'($urandom), 32'($urandom)};
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!dif.div_out_valid_o && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0]  op,
                        input logic        w,
                        input logic [63:0] a,
                        input logic [63:0] b);
    int lat, cyc;
    logic [63:0] exp;
    exp = model(op, w, a, b, lat);
    start(op, w, a, b);
    chk({tag, " busy"}, 64'(dif.busy_o), 64'd1);
    wait_valid(cyc);
    chk({tag, " lat"}, 64'(cyc), 64'(lat));
    chk({tag, " data"}, dif.div_out_o, exp);
    @(posedge clk);
    #1;
    chk({tag, " handoff"},
        64'({dif.div_out_valid_o, dif.div_ready_o}),
        64'b01);
  endtask

  initial begin
    int cyc, lat;
    logic [63:0] exp, prev;
    rst = 1'b1;
    dif.div_valid_i     = 1'b0;
    dif.div_op_i        = 2'b00;
    dif.div_word_i      = 1'b0;
    dif.dividend_i      = '0;
    dif.divisor_i       = '0;
    dif.flush_i         = 1'b0;
    dif.div_out_ready_i = 1'b1;
    #12;
    chk("rst out", dif.div_out_o, 64'h0);
    chk("rst valid", 64'(dif.div_out_valid_o), 64'd0);
    chk("rst busy", 64'(dif.busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst ready", 64'(dif.div_ready_o), 64'd1);

    run_op("div -20/3", 2'b00, 1'b0,
           64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    run_op("rem -20/3", 2'b10, 1'b0,
           64'hFFFF_FFFF_FFFF_FFEC, 64'd3);
    run_op("divu /0", 2'b01, 1'b0, 64'h1234, 64'h0);
    run_op("remu /0", 2'b11, 1'b0, 64'h1234, 64'h0);
    run_op("div ovf", 2'b00, 1'b0,
           64'h8000_0000_0000_0000, '1);
    run_op("rem ovf", 2'b10, 1'b0,
           64'h8000_0000_0000_0000, '1);
    run_op("divuw", 2'b01, 1'b1,
           64'hDEAD_0000_FFFF_FFFE, 64'h1_0000_0001);
    run_op("divw ovf", 2'b00, 1'b1,
           64'h1_8000_0000, 64'h0_FFFF_FFFF);
    run_op("remw /0", 2'b10, 1'b1,
           64'h7_8000_0005, 64'h5_0000_0000);

    // back-pressure in DONE
    dif.div_out_ready_i = 1'b0;
    exp = model(2'b01, 1'b0, 64'd1000, 64'd7, lat);
    start(2'b01, 1'b0, 64'd1000, 64'd7);
    wait_valid(cyc);
    chk("bp lat", 64'(cyc), 64'(lat));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp hold",
          {dif.div_out_o[60:0], dif.div_out_valid_o,
           dif.div_ready_o, dif.busy_o},
          {exp[60:0], 3'b101});
    end
    @(negedge clk);
    dif.div_out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release",
        64'({dif.div_out_valid_o, dif.div_ready_o}),
        64'b01);

    // flush mid-CALC
    prev = dif.div_out_o;
    start(2'b00, 1'b0, 64'd99999, 64'd13);
    repeat (19) @(posedge clk);
    @(negedge clk);
    dif.flush_i = 1'b1;
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0;
    chk("flush busy", 64'(dif.busy_o), 64'd0);
    chk("flush out", dif.div_out_o, prev);
    cyc = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (dif.div_out_valid_o) cyc++;
    end
    chk("flush no valid", 64'(cyc), 64'd0);

    // flush together with valid in IDLE
    @(negedge clk);
    dif.flush_i     = 1'b1;
    dif.div_valid_i = 1'b1;
    #1;
    chk("flush ready", 64'(dif.div_ready_o), 64'd0);
    @(posedge clk);
    #1;
    dif.flush_i     = 1'b0;
    dif.div_valid_i = 1'b0;
    chk("flush no acc", 64'(dif.busy_o), 64'd0);

    // flush with ready in DONE
    dif.div_out_ready_i = 1'b0;
    exp = model(2'b11, 1'b1, 64'd77, 64'd0, lat);
    start(2'b11, 1'b1, 64'd77, 64'd0);
    wait_valid(cyc);
    chk("fd lat", 64'(cyc), 64'(lat));
    @(negedge clk);
    dif.flush_i         = 1'b1;
    dif.div_out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    dif.flush_i = 1'b0;
    chk("fd valid", 64'(dif.div_out_valid_o), 64'd0);
    chk("fd out", dif.div_out_o, exp);

    // reset mid-CALC
    start(2'b00, 1'b0, 64'd12345, 64'd6);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst out", dif.div_out_o, 64'h0);
    chk("arst flags",
        64'({dif.div_out_valid_o, dif.busy_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst ready", 64'(dif.div_ready_o), 64'd1);

    for (int i = 0; i < 60; i++) begin
      run_op("rand", 2'($urandom), 1'($urandom),
             rnd_val(), rnd_val());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
